int_sched: RTL and testbench

- Interrupt and run-state scheduler for the 65C02 core.
- Arbitrates reset, NMI and IRQ requests at instruction boundaries and tells the microcode sequencer when to inject the interrupt sequence.
- Selects the register-file entry that holds the vector low byte.
- Implements the WAI and STP halt states. Sits beside the control unit and consumes its sync/ack handshake.

---
 rtl/int_sched.sv | 197 +++++++++++++++++++
 tb/tb_int_sched.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/int_sched.sv
// Interrupt and run-state scheduler for the 65C02 core: arbitrates RST/NMI/IRQ at
// instruction boundaries, selects the vector register-file entry and handles WAI/STP.
module int_sched #(
    parameter int RST_CYCLES = 2,
    parameter int NMI_SYNC   = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       IRQ,
    input  logic       NMI,
    input  logic       I,
    input  logic       sync,
    input  logic       ack,
    input  logic       wai,
    input  logic       stp,
    output logic       int_req,
    output logic [3:0] vec_sel,
    output logic       b_flag,
    output logic       halt
);

    localparam int CW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_TAKE  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [3:0] VEC_RST = 4'd9;
    localparam logic [3:0] VEC_NMI = 4'd8;
    localparam logic [3:0] VEC_IRQ = 4'd4;

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NMI_SYNC-1:0] nmi_sync_q, nmi_sync_d;
    logic                nmi_prev_q, nmi_prev_d;
    logic                nmi_pend_q, nmi_pend_d;
    logic [3:0]          vec_q, vec_d;
    logic                int_req_q, int_req_d;
    logic [3:0]          vec_sel_q, vec_sel_d;
    logic                halt_q, halt_d;
    logic                b_flag_q, b_flag_d;

    logic                nmi_edge_s;
    logic                irq_act_s;
    logic                run_req_s;
    logic [3:0]          run_vec_s;

    generate
        if (NMI_SYNC == 1) begin : g_sync1
            assign nmi_sync_d = NMI;
        end else begin : g_syncn
            assign nmi_sync_d = {nmi_sync_q[NMI_SYNC-2:0], NMI};
        end
    endgenerate

    // NMI edge capture and the request terms the RUN state acts on
    always_comb begin
        nmi_prev_d = nmi_sync_q[NMI_SYNC-1];
        nmi_edge_s = nmi_sync_q[NMI_SYNC-1] & ~nmi_prev_q;
        irq_act_s  = IRQ & ~I;
        b_flag_d   = 1'b0;
        // a fresh edge beats the clear from acknowledging the previous NMI
        if (nmi_edge_s) begin
            nmi_pend_d = 1'b1;
        end else if ((state_q == ST_TAKE) && ack && (vec_q == VEC_NMI)) begin
            nmi_pend_d = 1'b0;
        end else begin
            nmi_pend_d = nmi_pend_q;
        end
        run_req_s = nmi_pend_d | irq_act_s;
        run_vec_s = nmi_pend_d ? VEC_NMI : VEC_IRQ;
    end

    // Run-state machine and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        int_req_d = int_req_q;
        vec_sel_d = vec_sel_q;
        halt_d    = halt_q;
        case (state_q)
            ST_RESET: begin
                int_req_d = 1'b1;
                vec_sel_d = VEC_RST;
                halt_d    = 1'b0;
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (ack && (cnt_q == {CW{1'b0}})) begin
                    state_d   = ST_RUN;
                    int_req_d = 1'b0;
                    vec_sel_d = run_vec_s;
                end else begin
                    state_d = ST_RESET;
                end
            end
            ST_RUN: begin
                int_req_d = run_req_s;
                vec_sel_d = run_vec_s;
                halt_d    = 1'b0;
                if (sync && int_req_q) begin
                    state_d   = ST_TAKE;
                    vec_d     = vec_sel_q;
                    int_req_d = 1'b1;
                    vec_sel_d = vec_sel_q;
                end else if (stp) begin
                    state_d   = ST_STOP;
                    int_req_d = 1'b0;
                    halt_d    = 1'b1;
                end else if (wai) begin
                    state_d   = ST_WAIT;
                    int_req_d = 1'b0;
                    halt_d    = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_TAKE: begin
                int_req_d = 1'b1;
                vec_sel_d = vec_q;
                halt_d    = 1'b0;
                if (ack) begin
                    state_d   = ST_RUN;
                    int_req_d = run_req_s;
                    vec_sel_d = run_vec_s;
                end else begin
                    state_d = ST_TAKE;
                end
            end
            ST_WAIT: begin
                int_req_d = 1'b0;
                halt_d    = 1'b1;
                // IRQ wakes the core even when masked; RUN then decides on int_req
                if (stp) begin
                    state_d = ST_STOP;
                end else if (IRQ || nmi_pend_q) begin
                    state_d   = ST_RUN;
                    halt_d    = 1'b0;
                    int_req_d = run_req_s;
                    vec_sel_d = run_vec_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_STOP: begin
                state_d   = ST_STOP;
                int_req_d = 1'b0;
                halt_d    = 1'b1;
            end
            default: begin
                state_d   = ST_RESET;
                cnt_d     = CW'(RST_CYCLES);
                int_req_d = 1'b1;
                vec_sel_d = VEC_RST;
                halt_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_RESET;
            cnt_q      <= CW'(RST_CYCLES);
            nmi_sync_q <= {NMI_SYNC{1'b0}};
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            vec_q      <= VEC_RST;
            int_req_q  <= 1'b1;
            vec_sel_q  <= VEC_RST;
            halt_q     <= 1'b0;
            b_flag_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nmi_sync_q <= nmi_sync_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
            vec_q      <= vec_d;
            int_req_q  <= int_req_d;
            vec_sel_q  <= vec_sel_d;
            halt_q     <= halt_d;
            b_flag_q   <= b_flag_d;
        end
    end

    assign int_req = int_req_q;
    assign vec_sel = vec_sel_q;
    assign halt    = halt_q;
    assign b_flag  = b_flag_q;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: a vector table for reset/IRQ/NMI sequencing plus
// hand-written WAI and STP sequences.
module tb_int_sched;

    logic       clk = 1'b0;
    logic       RST, IRQ, NMI, I, sync, ack, wai, stp;
    logic       int_req;
    logic [3:0] vec_sel;
    logic       b_flag, halt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst, irq, nmi, i, sy, ak, wa, st;
        logic       e_req;
        logic [3:0] e_vec;
        logic       e_halt;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    int_sched #(.RST_CYCLES(2), .NMI_SYNC(2)) dut (
        .clk(clk), .RST(RST), .IRQ(IRQ), .NMI(NMI), .I(I),
        .sync(sync), .ack(ack), .wai(wai), .stp(stp),
        .int_req(int_req), .vec_sel(vec_sel), .b_flag(b_flag), .halt(halt)
    );

    task automatic add(input logic rst, irq, nmi, i, sy, ak, wa, st,
                       input logic er, input logic [3:0] ev, input logic eh);
        vec_t v;
        v.rst = rst; v.irq = irq; v.nmi = nmi; v.i = i;
        v.sy = sy; v.ak = ak; v.wa = wa; v.st = st;
        v.e_req = er; v.e_vec = ev; v.e_halt = eh;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, irq, nmi, i, sy, ak, wa, st);
        RST = rst; IRQ = irq; NMI = nmi; I = i;
        sync = sy; ack = ak; wai = wa; stp = st;
    endtask

    task automatic check(input string nm, input logic er, input logic [3:0] ev, input logic eh);
        n_cmp++;
        if ({int_req, vec_sel, halt, b_flag} !== {er, ev, eh, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: got req=%b vec=%0d halt=%b b=%b, want req=%b vec=%0d halt=%b b=0",
                     nm, int_req, vec_sel, halt, b_flag, er, ev, eh);
        end
    endtask

    task automatic step(input logic rst, irq, nmi, i, sy, ak, wa, st, input string nm,
                        input logic er, input logic [3:0] ev, input logic eh);
        drive(rst, irq, nmi, i, sy, ak, wa, st);
        @(posedge clk);
        #1;
        check(nm, er, ev, eh);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset release: early ack ignored, ack once the counter expires
        add(1,0,0,0,0,0,0,0, 1,4'd9,0);
        add(1,0,0,0,0,0,0,0, 1,4'd9,0);
        add(1,0,0,0,0,0,0,0, 1,4'd9,0);
        add(0,0,0,0,0,0,0,0, 1,4'd9,0);
        add(0,0,0,0,0,1,0,0, 1,4'd9,0);
        add(0,0,0,0,0,0,0,0, 1,4'd9,0);
        add(0,0,0,0,0,1,0,0, 0,4'd4,0);
        // IRQ masked by I, then unmasked and taken
        add(0,1,0,1,1,0,0,0, 0,4'd4,0);
        add(0,1,0,1,0,0,0,0, 0,4'd4,0);
        add(0,1,0,1,1,0,0,0, 0,4'd4,0);
        add(0,1,0,0,0,0,0,0, 1,4'd4,0);
        add(0,1,0,0,1,0,0,0, 1,4'd4,0);
        add(0,1,0,0,1,0,0,0, 1,4'd4,0);
        add(0,0,0,0,0,1,0,0, 0,4'd4,0);
        add(0,0,0,0,0,0,0,0, 0,4'd4,0);
        // NMI over IRQ, single request for a held level
        add(0,1,1,0,0,0,0,0, 1,4'd4,0);
        add(0,1,1,0,0,0,0,0, 1,4'd4,0);
        add(0,1,1,0,0,0,0,0, 1,4'd8,0);
        add(0,1,1,0,1,0,0,0, 1,4'd8,0);
        add(0,1,1,0,0,1,0,0, 1,4'd4,0);
        add(0,1,1,0,0,0,0,0, 1,4'd4,0);
        add(0,0,1,0,0,0,0,0, 0,4'd4,0);
        add(0,0,0,0,0,0,0,0, 0,4'd4,0);
        add(0,0,0,0,0,0,0,0, 0,4'd4,0);
        add(0,0,0,0,0,0,0,0, 0,4'd4,0);
        // NMI arriving while an IRQ sequence is in TAKE
        add(0,1,0,0,0,0,0,0, 1,4'd4,0);
        add(0,1,1,0,1,0,0,0, 1,4'd4,0);
        add(0,1,1,0,0,0,0,0, 1,4'd4,0);
        add(0,1,1,0,0,0,0,0, 1,4'd4,0);
        add(0,1,1,0,0,0,0,0, 1,4'd4,0);
        add(0,0,1,0,0,1,0,0, 1,4'd8,0);
        add(0,0,1,0,1,0,0,0, 1,4'd8,0);
        add(0,0,1,0,0,1,0,0, 0,4'd4,0);
        add(0,0,0,0,0,0,0,0, 0,4'd4,0);
        add(0,0,0,0,0,0,0,0, 0,4'd4,0);
        add(0,0,0,0,0,0,0,0, 0,4'd4,0);

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].rst, tbl[k].irq, tbl[k].nmi, tbl[k].i,
                  tbl[k].sy, tbl[k].ak, tbl[k].wa, tbl[k].st);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_vec, tbl[k].e_halt);
        end

        // WAI, woken by a masked IRQ: no interrupt
        step(0,0,0,1,0,0,1,0, "wai_enter", 0,4'd4,1);
        for (int k = 0; k < 10; k++) step(0,0,0,1,0,0,0,0, "wai_hold", 0,4'd4,1);
        step(0,1,0,1,0,0,0,0, "wai_wake_masked", 0,4'd4,0);
        step(0,1,0,1,1,1,0,0, "ack_in_run", 0,4'd4,0);
        step(0,0,0,0,0,0,0,0, "idle", 0,4'd4,0);
        // WAI, woken by an unmasked IRQ: interrupt follows
        step(0,0,0,0,0,0,1,0, "wai2_enter", 0,4'd4,1);
        for (int k = 0; k < 3; k++) step(0,0,0,0,0,0,0,0, "wai2_hold", 0,4'd4,1);
        step(0,1,0,0,0,0,0,0, "wai2_wake", 1,4'd4,0);
        step(0,1,0,0,1,0,0,0, "wai2_take", 1,4'd4,0);
        step(0,0,0,0,0,1,0,0, "wai2_ack", 0,4'd4,0);
        // wake condition already present on entry: one halt cycle
        step(0,1,0,1,0,0,1,0, "wai3_enter", 0,4'd4,1);
        step(0,1,0,1,0,0,0,0, "wai3_wake", 0,4'd4,0);
        step(0,0,0,0,0,0,0,0, "idle2", 0,4'd4,0);
        // wai/stp inside TAKE are ignored
        step(0,1,0,0,0,0,0,0, "take_req", 1,4'd4,0);
        step(0,1,0,0,1,0,0,0, "take_enter", 1,4'd4,0);
        step(0,1,0,0,0,0,1,1, "take_wai_stp", 1,4'd4,0);
        step(0,0,0,0,0,1,0,0, "take_ack", 0,4'd4,0);

        // STP: only RST leaves
        step(0,0,0,0,0,0,0,1, "stp_enter", 0,4'd4,1);
        for (int k = 0; k < 20; k++)
            step(0, k[0], ((k % 4) < 2) ? 1'b1 : 1'b0, 0, 0, 0, 0, 0, "stp_hold", 0,4'd4,1);
        step(1,0,0,0,0,0,0,0, "stp_rst", 1,4'd9,0);
        step(0,0,0,0,0,0,0,1, "rst_stp_ign", 1,4'd9,0);
        step(0,0,0,0,0,0,0,0, "rst_cnt", 1,4'd9,0);
        step(0,0,0,0,0,1,0,0, "rst_ack", 0,4'd4,0);
        // wai and stp together: stp wins, IRQ cannot wake
        step(0,0,0,0,0,0,1,1, "waistp_enter", 0,4'd4,1);
        for (int k = 0; k < 3; k++) step(0,1,0,0,0,0,0,0, "waistp_hold", 0,4'd4,1);
        step(1,0,0,0,0,0,0,0, "final_rst", 1,4'd9,0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
